seven_segment_capture: RTL and testbench

Receive-side counterpart to the four-digit seven-segment display driver. Samples the multiplexed active-low segment lines (CA–CG, DP) and anode lines (AN1–AN4), filters scan transitions and ghosting, and decodes each glyph back to a 4-bit hex value. The result is four registered digits plus decimal points, with validity, frame and error status. Used in loopback self-test and bench scoreboarding of the display path.

---
 rtl/seven_segment_capture.sv | 274 +++++++++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: receive side of a 4-digit multiplexed seven-segment
// display. Registers the active-low segment/anode pins, waits for a scan slot
// to settle, decodes the glyph back to hex and tracks validity, frames,
// illegal glyphs, anode conflicts and staleness.
// Optional anode duty estimate: define SEVEN_SEG_CAPTURE_BRIGHTNESS_EN.
module seven_segment_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       CA,
    input  logic       CB,
    input  logic       CC,
    input  logic       CD,
    input  logic       CE,
    input  logic       CF,
    input  logic       CG,
    input  logic       DP,
    input  logic       AN1,
    input  logic       AN2,
    input  logic       AN3,
    input  logic       AN4,
    output logic [3:0] sec_dig1,
    output logic [3:0] sec_dig2,
    output logic [3:0] min_dig1,
    output logic [3:0] min_dig2,
    output logic [3:0] decimal_point,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       seg_err,
    output logic       anode_conflict,
    output logic       timeout,
    output logic [7:0] brightness
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
    // Counter value on the cycle before it would reach STABLE_CYCLES-1.
    localparam logic [7:0] CAPTURE_AT = 8'(STABLE_CYCLES - 2);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD, CONFLICT} state_t;

    // Pins converted to active-high: seg bit 6 = a ... bit 0 = g; an bit i = AN(i+1).
    logic [6:0]  seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [3:0]  an_q, an_d;
    logic [11:0] pat_prev_q, pat_prev_d;
    logic [7:0]  stab_q, stab_d;
    state_t      state_q, state_d;
    logic [3:0]  dp_pt_q, dp_pt_d;
    logic [3:0]  valid_q, valid_d;
    logic [3:0]  seen_q, seen_d;
    logic        frame_q, frame_d;
    logic        err_q, err_d;
    logic        conflict_q, conflict_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;

    logic [2:0]  an_count;
    logic        one_hot;
    logic        pat_same;
    logic        capture;
    logic        glyph_legal;
    logic        glyph_blank;
    logic [3:0]  glyph_val;

    // Input stage: invert to active-high and remember the previous sample.
    always_comb begin
        seg_d      = ~{CA, CB, CC, CD, CE, CF, CG};
        dp_d       = ~DP;
        an_d       = ~{AN4, AN3, AN2, AN1};
        pat_prev_d = {seg_q, dp_q, an_q};
    end

    // Input and previous-sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q      <= '0;
            dp_q       <= 1'b0;
            an_q       <= '0;
            pat_prev_q <= '0;
        end else begin
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            pat_prev_q <= pat_prev_d;
        end
    end

    // Anode count, stability filter and capture strobe.
    always_comb begin
        an_count = {2'b00, an_q[0]} + {2'b00, an_q[1]} + {2'b00, an_q[2]} + {2'b00, an_q[3]};
        one_hot  = (an_count == 3'd1);
        pat_same = ({seg_q, dp_q, an_q} == pat_prev_q);
        stab_d   = 8'd0;
        if (one_hot && pat_same)
            stab_d = (stab_q == 8'hFF) ? stab_q : stab_q + 8'd1;
        capture  = (state_q == TRACK) && one_hot && pat_same && (stab_q == CAPTURE_AT);
    end

    // Next state chosen each cycle from the anode count; HOLD blocks re-capture.
    always_comb begin
        state_d = TRACK;
        if (an_count > 3'd1)
            state_d = CONFLICT;
        else if (an_count == 3'd0)
            state_d = IDLE;
        else if ((state_q == HOLD) && pat_same)
            state_d = HOLD;
        else if (capture)
            state_d = HOLD;
    end

    // Glyph decoder: legal hex glyphs, blank, or illegal.
    always_comb begin
        glyph_legal = 1'b1;
        glyph_blank = 1'b0;
        glyph_val   = 4'h0;
        case (seg_q)
            7'h7E: glyph_val = 4'h0;
            7'h30: glyph_val = 4'h1;
            7'h6D: glyph_val = 4'h2;
            7'h79: glyph_val = 4'h3;
            7'h33: glyph_val = 4'h4;
            7'h5B: glyph_val = 4'h5;
            7'h5F: glyph_val = 4'h6;
            7'h70: glyph_val = 4'h7;
            7'h7F: glyph_val = 4'h8;
            7'h7B: glyph_val = 4'h9;
            7'h77: glyph_val = 4'hA;
            7'h1F: glyph_val = 4'hB;
            7'h4E: glyph_val = 4'hC;
            7'h3D: glyph_val = 4'hD;
            7'h4F: glyph_val = 4'hE;
            7'h47: glyph_val = 4'hF;
            7'h00: begin
                glyph_legal = 1'b0;
                glyph_blank = 1'b1;
            end
            default: glyph_legal = 1'b0;
        endcase
    end

    // One value register per digit, written only on a legal capture of its anode.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] digit_q, digit_d;

            // Load the decoded value when this digit's slot is captured.
            always_comb begin
                digit_d = digit_q;
                if (capture && an_q[gi] && glyph_legal)
                    digit_d = glyph_val;
            end

            // Digit value register.
            always_ff @(posedge clk) begin
                if (reset)
                    digit_q <= 4'h0;
                else
                    digit_q <= digit_d;
            end
        end
    endgenerate

    // Status: valid/seen masks, pulses, conflict flag and staleness timer.
    always_comb begin
        dp_pt_d    = dp_pt_q;
        valid_d    = valid_q;
        seen_d     = seen_q;
        frame_d    = 1'b0;
        err_d      = 1'b0;
        conflict_d = conflict_q | (an_count > 3'd1);
        tmo_cnt_d  = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TW'(1);
        timeout_d  = 1'b0;
        if (capture) begin
            // A capture always wins over an expiring timer.
            tmo_cnt_d = '0;
            if (glyph_legal) begin
                dp_pt_d = (dp_pt_q & ~an_q) | (an_q & {4{dp_q}});
                valid_d = valid_q | an_q;
                seen_d  = seen_q | an_q;
            end else if (glyph_blank) begin
                valid_d = valid_q & ~an_q;
                seen_d  = seen_q | an_q;
            end else begin
                err_d = 1'b1;
            end
            if (seen_d == 4'hF) begin
                frame_d = 1'b1;
                seen_d  = 4'h0;
            end
        end else if (tmo_cnt_d == TMO_MAX) begin
            valid_d   = 4'h0;
            seen_d    = 4'h0;
            timeout_d = 1'b1;
        end
    end

    // FSM, filter and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            stab_q     <= '0;
            dp_pt_q    <= '0;
            valid_q    <= '0;
            seen_q     <= '0;
            frame_q    <= 1'b0;
            err_q      <= 1'b0;
            conflict_q <= 1'b0;
            tmo_cnt_q  <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            stab_q     <= stab_d;
            dp_pt_q    <= dp_pt_d;
            valid_q    <= valid_d;
            seen_q     <= seen_d;
            frame_q    <= frame_d;
            err_q      <= err_d;
            conflict_q <= conflict_d;
            tmo_cnt_q  <= tmo_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

`ifdef SEVEN_SEG_CAPTURE_BRIGHTNESS_EN
    logic [7:0] win_q, win_d;
    logic [8:0] on_q, on_d;
    logic [8:0] on_sum;
    logic [7:0] bright_q, bright_d;

    // Count anode-on cycles per 256-cycle window and publish at window end.
    always_comb begin
        win_d    = win_q + 8'd1;
        on_sum   = on_q + {8'd0, (an_count != 3'd0)};
        on_d     = on_sum;
        bright_d = bright_q;
        if (win_q == 8'hFF) begin
            bright_d = (on_sum > 9'd255) ? 8'hFF : on_sum[7:0];
            on_d     = 9'd0;
        end
    end

    // Brightness window registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q    <= '0;
            on_q     <= '0;
            bright_q <= '0;
        end else begin
            win_q    <= win_d;
            on_q     <= on_d;
            bright_q <= bright_d;
        end
    end

    assign brightness = bright_q;
`else
    assign brightness = 8'd0;
`endif

    assign sec_dig1       = g_digit[0].digit_q;
    assign sec_dig2       = g_digit[1].digit_q;
    assign min_dig1       = g_digit[2].digit_q;
    assign min_dig2       = g_digit[3].digit_q;
    assign decimal_point  = dp_pt_q;
    assign digit_valid    = valid_q;
    assign frame_done     = frame_q;
    assign seg_err        = err_q;
    assign anode_conflict = conflict_q;
    assign timeout        = timeout_q;
endmodule

// File: tb/tb_seven_segment_capture.sv
// Scoreboard bench for seven_segment_capture: expected frame/seg_err events are
// queued by the stimulus, and a monitor compares each DUT pulse against them.
module tb_seven_segment_capture;
    localparam int STABLE = 4;
    localparam int TMO    = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic CA, CB, CC, CD, CE, CF, CG, DP, AN1, AN2, AN3, AN4;
    logic [3:0] sec_dig1, sec_dig2, min_dig1, min_dig2;
    logic [3:0] decimal_point, digit_valid;
    logic frame_done, seg_err, anode_conflict, timeout;
    logic [7:0] brightness;

    seven_segment_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG), .DP(DP),
        .AN1(AN1), .AN2(AN2), .AN3(AN3), .AN4(AN4),
        .sec_dig1(sec_dig1), .sec_dig2(sec_dig2), .min_dig1(min_dig1), .min_dig2(min_dig2),
        .decimal_point(decimal_point), .digit_valid(digit_valid),
        .frame_done(frame_done), .seg_err(seg_err), .anode_conflict(anode_conflict),
        .timeout(timeout), .brightness(brightness)
    );

    always #5 clk = ~clk;

    // abcdefg lit patterns for hex 0..F
    localparam logic [6:0] GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    typedef struct packed {
        logic [15:0] digits;   // {min_dig2, min_dig1, sec_dig2, sec_dig1}
        logic [3:0]  dp;
        logic [3:0]  valid;
        logic        fd;
        logic        se;
    } rec_t;

    rec_t exp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic expect_ev(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] v,
                             input logic fd, input logic se);
        rec_t r;
        r = '{digits: d, dp: dp, valid: v, fd: fd, se: se};
        exp_q.push_back(r);
    endtask

    task automatic set_pins(input logic [3:0] an, input logic [6:0] seg, input logic dp);
        {CA, CB, CC, CD, CE, CF, CG} = ~seg;
        DP = ~dp;
        {AN4, AN3, AN2, AN1} = ~an;
    endtask

    // Drive a pattern and hold it for n clock edges.
    task automatic apply(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int n);
        set_pins(an, seg, dp);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full scan round, 8 cycles per digit.
    task automatic scan(input int v0, input int v1, input int v2, input int v3, input logic [3:0] dps);
        apply(4'b0001, GLYPH[v0], dps[0], 8);
        apply(4'b0010, GLYPH[v1], dps[1], 8);
        apply(4'b0100, GLYPH[v2], dps[2], 8);
        apply(4'b1000, GLYPH[v3], dps[3], 8);
    endtask

    // Monitor: every frame_done/seg_err pulse must match the next queued record.
    always @(negedge clk) begin
        rec_t got;
        rec_t e;
        if (!reset && (frame_done || seg_err)) begin
            got = '{digits: {min_dig2, min_dig1, sec_dig2, sec_dig1}, dp: decimal_point,
                    valid: digit_valid, fd: frame_done, se: seg_err};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL event_unexpected: got %h expected none", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL event: got %h expected %h", got, e);
                end else begin
                    $display("ok   event: %h", got);
                end
            end
        end
    end

    initial begin
        set_pins(4'b0000, 7'h00, 1'b0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_digits", {16'h0, min_dig2, min_dig1, sec_dig2, sec_dig1}, 32'h0);
        check("reset_valid", {28'h0, digit_valid}, 32'h0);
        check("reset_flags", {28'h0, frame_done, seg_err, anode_conflict, timeout}, 32'h0);
        check("reset_dp", {28'h0, decimal_point}, 32'h0);

        // Full scans with varied glyphs and decimal points
        expect_ev(16'h4321, 4'b0000, 4'hF, 1'b1, 1'b0);
        scan(1, 2, 3, 4, 4'b0000);
        expect_ev(16'h8765, 4'b0010, 4'hF, 1'b1, 1'b0);
        scan(5, 6, 7, 8, 4'b0010);
        expect_ev(16'hDCBA, 4'b1001, 4'hF, 1'b1, 1'b0);
        scan(10, 11, 12, 13, 4'b1001);
        expect_ev(16'h09FE, 4'b1111, 4'hF, 1'b1, 1'b0);
        scan(14, 15, 9, 0, 4'b1111);

        // Slots held for STABLE-1 cycles never capture
        for (int i = 0; i < 4; i++) apply(4'b0001 << i, GLYPH[8], 1'b0, STABLE - 1);
        apply(4'b0000, 7'h00, 1'b0, 2);
        check("hold3_sec_dig1", {28'h0, sec_dig1}, 32'hE);
        check("hold3_min_dig2", {28'h0, min_dig2}, 32'h0);

        // Illegal glyph (a,d) on AN2
        expect_ev(16'h09FE, 4'b1111, 4'hF, 1'b0, 1'b1);
        apply(4'b0010, 7'h48, 1'b0, 6);
        check("segerr_sec_dig2", {28'h0, sec_dig2}, 32'hF);
        check("segerr_valid", {28'h0, digit_valid}, 32'hF);

        // Blank on AN3 clears its valid bit only
        apply(4'b0100, 7'h00, 1'b0, 6);
        check("blank_valid", {28'h0, digit_valid}, 32'hB);
        check("blank_min_dig1", {28'h0, min_dig1}, 32'h9);
        check("blank_dp", {28'h0, decimal_point}, 32'hF);

        // Blank counts as seen: three more digits complete the frame
        expect_ev(16'h4921, 4'b0100, 4'b1011, 1'b1, 1'b0);
        apply(4'b0001, GLYPH[1], 1'b0, 8);
        apply(4'b0010, GLYPH[2], 1'b0, 8);
        apply(4'b1000, GLYPH[4], 1'b0, 8);

        // Two anodes at once for a single cycle
        check("conflict_before", {31'h0, anode_conflict}, 32'h0);
        apply(4'b0101, GLYPH[8], 1'b0, 1);
        apply(4'b0000, 7'h00, 1'b0, 3);
        check("conflict_after", {31'h0, anode_conflict}, 32'h1);

        // Timeout boundary: last capture is 3 edges before the end of the scan
        expect_ev(16'h4321, 4'b0000, 4'hF, 1'b1, 1'b0);
        scan(1, 2, 3, 4, 4'b0000);
        apply(4'b0000, 7'h00, 1'b0, TMO - 4);
        check("tmo_before", {31'h0, timeout}, 32'h0);
        check("tmo_before_valid", {28'h0, digit_valid}, 32'hF);
        apply(4'b0000, 7'h00, 1'b0, 1);
        check("tmo_at", {31'h0, timeout}, 32'h1);
        check("tmo_at_valid", {28'h0, digit_valid}, 32'h0);
        apply(4'b0001, GLYPH[7], 1'b0, 6);
        check("tmo_cleared", {31'h0, timeout}, 32'h0);
        check("tmo_recover_valid", {28'h0, digit_valid}, 32'h1);
        check("tmo_recover_digit", {28'h0, sec_dig1}, 32'h7);
        check("conflict_sticky", {31'h0, anode_conflict}, 32'h1);

`ifdef SEVEN_SEG_CAPTURE_BRIGHTNESS_EN
        for (int i = 0; i < 300; i++) begin
            apply(4'b0001, GLYPH[1], 1'b0, 1);
            apply(4'b0000, 7'h00, 1'b0, 1);
        end
        check("brightness_50pct_in_127_129",
              {31'h0, (brightness >= 8'd127) && (brightness <= 8'd129)}, 32'h1);
`else
        for (int i = 0; i < 150; i++) begin
            apply(4'b0001, GLYPH[1], 1'b0, 1);
            apply(4'b0000, 7'h00, 1'b0, 1);
        end
        check("brightness_off", {24'h0, brightness}, 32'h0);
`endif

        // Reset clears everything including the sticky conflict flag
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_conflict", {31'h0, anode_conflict}, 32'h0);
        check("rst2_valid", {28'h0, digit_valid}, 32'h0);
        check("rst2_digits", {16'h0, min_dig2, min_dig1, sec_dig2, sec_dig1}, 32'h0);
        check("rst2_timeout_dp", {27'h0, timeout, decimal_point}, 32'h0);
        reset = 1'b0;
        apply(4'b0000, 7'h00, 1'b0, 2);

        check("pending_events", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
